// File: rtl/instr_decoder.sv
// Two-byte SPI command decoder: a command byte (rw, addr) followed by a data byte,
// producing one-cycle read/write strobes for the PWM register file.
module instr_decoder (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cs_active,
    input  logic       byte_sync,
    input  logic [7:0] data_in,
    output logic [7:0] data_out,
    output logic       read,
    output logic       write,
    output logic [5:0] addr,
    input  logic [7:0] data_read,
    output logic [7:0] data_write
);

    typedef enum logic {
        IDLE = 1'b0,
        DATA = 1'b1
    } state_t;

    state_t     state_q, state_d;
    logic       rw_q, rw_d;
    logic [5:0] addr_q, addr_d;
    logic [7:0] data_write_q, data_write_d;
    logic [7:0] data_out_q, data_out_d;
    logic       read_q, read_d;
    logic       write_q, write_d;

    always_comb begin
        state_d      = state_q;
        rw_d         = rw_q;
        addr_d       = addr_q;
        data_write_d = data_write_q;
        data_out_d   = data_out_q;
        read_d       = 1'b0;
        write_d      = 1'b0;

        if (!cs_active) begin
            state_d = IDLE;
        end else if (byte_sync) begin
            case (state_q)
                IDLE: begin
                    addr_d  = data_in[5:0];
                    rw_d    = data_in[7];
                    state_d = DATA;
                    if (data_in[7]) begin
                        data_out_d = 8'h00;
                    end else begin
                        read_d = 1'b1;
                    end
                end
                DATA: begin
                    if (rw_q) begin
                        write_d      = 1'b1;
                        data_write_d = data_in;
                    end
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end

        // The register file answers combinationally while read is high.
        if (read_q) begin
            data_out_d = data_read;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            rw_q         <= 1'b0;
            addr_q       <= 6'h00;
            data_write_q <= 8'h00;
            data_out_q   <= 8'h00;
            read_q       <= 1'b0;
            write_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            rw_q         <= rw_d;
            addr_q       <= addr_d;
            data_write_q <= data_write_d;
            data_out_q   <= data_out_d;
            read_q       <= read_d;
            write_q      <= write_d;
        end
    end

    assign data_out   = data_out_q;
    assign read       = read_q;
    assign write      = write_q;
    assign addr       = addr_q;
    assign data_write = data_write_q;

endmodule

// File: tb/tb_instr_decoder.sv
// Scoreboard bench for instr_decoder: stimulus pushes expected strobes derived from a
// frame-level model; a monitor pops and compares every strobe the DUT emits.
module tb_instr_decoder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cs_active;
    logic       byte_sync;
    logic [7:0] data_in;
    logic [7:0] data_out;
    logic       read;
    logic       write;
    logic [5:0] addr;
    logic [7:0] data_read;
    logic [7:0] data_write;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic       is_wr;
        logic [5:0] a;
        logic [7:0] d;
    } exp_t;

    exp_t sb[$];

    // Emulated register file (driven by DUT strobes) and the model's own copy.
    logic [7:0] seed_mem [64];
    logic [7:0] rf_mem   [64];
    logic [7:0] ref_mem  [64];
    logic       load;

    // Frame-level model state
    bit         m_in_data;
    bit         m_rw;
    logic [5:0] m_addr;
    logic [7:0] m_dout;
    logic [7:0] m_dw;

    logic       dout_pend;
    logic [7:0] dout_exp;

    instr_decoder dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cs_active  (cs_active),
        .byte_sync  (byte_sync),
        .data_in    (data_in),
        .data_out   (data_out),
        .read       (read),
        .write      (write),
        .addr       (addr),
        .data_read  (data_read),
        .data_write (data_write)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (load) begin
            for (int i = 0; i < 64; i++) rf_mem[i] <= seed_mem[i];
        end else if (write) begin
            rf_mem[addr] <= data_write;
        end
    end

    assign data_read = rf_mem[addr];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    // One call per clock of stimulus; mirrors the frame rules, not the RTL structure.
    task automatic model_cycle(input logic cs, input logic sync, input logic [7:0] b);
        exp_t e;
        if (!cs) begin
            m_in_data = 0;
        end else if (sync) begin
            if (!m_in_data) begin
                m_addr    = b[5:0];
                m_rw      = b[7];
                m_in_data = 1;
                if (b[7]) begin
                    m_dout = 8'h00;
                end else begin
                    e.is_wr = 1'b0; e.a = b[5:0]; e.d = ref_mem[b[5:0]];
                    sb.push_back(e);
                    m_dout = ref_mem[b[5:0]];
                end
            end else begin
                if (m_rw) begin
                    e.is_wr = 1'b1; e.a = m_addr; e.d = b;
                    sb.push_back(e);
                    ref_mem[m_addr] = b;
                    m_dw = b;
                end
                m_in_data = 0;
            end
        end
    endtask

    task automatic model_reset();
        m_in_data = 0;
        m_rw      = 0;
        m_addr    = 6'h00;
        m_dout    = 8'h00;
        m_dw      = 8'h00;
        sb.delete();
    endtask

    task automatic drive(input logic cs, input logic sync, input logic [7:0] b);
        @(negedge clk);
        cs_active = cs;
        byte_sync = sync;
        data_in   = b;
        model_cycle(cs, sync, b);
    endtask

    task automatic settle_check(input string tag);
        repeat (3) drive(1'b1, 1'b0, 8'h00);
        check({tag, "_addr"},       32'(addr),       32'(m_addr));
        check({tag, "_data_out"},   32'(data_out),   32'(m_dout));
        check({tag, "_data_write"}, 32'(data_write), 32'(m_dw));
    endtask

    // Monitor: every strobe must match the head of the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            dout_pend <= 1'b0;
        end else begin
            if (dout_pend) begin
                check("read_data_out", 32'(data_out), 32'(dout_exp));
                dout_pend <= 1'b0;
            end
            if (read && write) begin
                check("strobe_overlap", 32'({read, write}), 32'h1);
            end
            if (read || write) begin
                if (sb.size() == 0) begin
                    check("unexpected_strobe", 32'({read, write}), 32'h0);
                end else begin
                    e = sb.pop_front();
                    $display("txn %s addr=0x%02h data=0x%02h", write ? "write" : "read ", addr,
                             write ? data_write : data_read);
                    check("strobe_kind", 32'(write), 32'(e.is_wr));
                    check("strobe_addr", 32'(addr),  32'(e.a));
                    if (e.is_wr) begin
                        check("write_data", 32'(data_write), 32'(e.d));
                    end else begin
                        dout_pend <= 1'b1;
                        dout_exp  <= e.d;
                    end
                end
            end
        end
    end

    initial begin
        logic cs_r, sync_r;
        logic [7:0] b_r;
        rst_n     = 1'b0;
        cs_active = 1'b0;
        byte_sync = 1'b0;
        data_in   = 8'h00;
        load      = 1'b1;
        dout_pend = 1'b0;
        dout_exp  = 8'h00;
        for (int i = 0; i < 64; i++) begin
            seed_mem[i] = 8'($urandom);
            ref_mem[i]  = seed_mem[i];
        end
        seed_mem[3] = 8'h5A;
        ref_mem[3]  = 8'h5A;
        model_reset();

        repeat (3) @(negedge clk);
        check("reset_outputs", 32'({read, write, addr, data_write, data_out}), 32'h0);
        load  = 1'b0;
        rst_n = 1'b1;

        // Write 0x81, 0x34
        drive(1, 1, 8'h81); drive(1, 1, 8'h34);
        settle_check("write");

        // Read 0x03 (0x5A), dummy 0xFF
        drive(1, 1, 8'h03); drive(1, 0, 8'h00); drive(1, 1, 8'hFF);
        settle_check("read");

        // Reserved bit set: 0xC3, 0x77
        drive(1, 1, 8'hC3); drive(1, 0, 8'h00); drive(1, 1, 8'h77);
        settle_check("reserved");

        // Frame abort then read command 0x05
        drive(1, 1, 8'h82); drive(0, 0, 8'h00); drive(0, 1, 8'h99); drive(1, 1, 8'h05);
        settle_check("abort");

        // Back-to-back bytes
        drive(1, 1, 8'h8A); drive(1, 1, 8'h10); drive(1, 1, 8'h0A);
        settle_check("b2b");

        // Asynchronous reset mid-frame
        drive(1, 1, 8'h84); drive(1, 0, 8'h00);
        #3 rst_n = 1'b0;
        model_reset();
        #1 check("async_reset_outputs", 32'({read, write, addr, data_write, data_out}), 32'h0);
        @(negedge clk);
        check("held_reset_outputs", 32'({read, write, addr, data_write, data_out}), 32'h0);
        rst_n = 1'b1;
        drive(1, 1, 8'h22);
        settle_check("post_reset");

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            cs_r   = ($urandom_range(0, 9) != 0);
            sync_r = 1'($urandom_range(0, 1));
            b_r    = 8'($urandom);
            drive(cs_r, sync_r, b_r);
            if (n % 50 == 49) settle_check("random");
        end
        settle_check("final");
        check("scoreboard_drained", 32'(sb.size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
